// File: rtl/ntt_butterfly_seq.sv
// Sequential modular NTT butterfly (CT forward / GS inverse) with a shift-add modular multiplier.
// Optional macro BU_RANGE_CHECK_EN flags out-of-range operands and reports them on err.
module ntt_butterfly_seq #(
    parameter int BIT_SIZE = 60
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                mode,
    input  logic [BIT_SIZE-1:0] A0,
    input  logic [BIT_SIZE-1:0] A1,
    input  logic [BIT_SIZE-1:0] Y,
    input  logic [BIT_SIZE-1:0] q,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BIT_SIZE-1:0] B0,
    output logic [BIT_SIZE-1:0] B1,
    output logic                err
);
    // Handshake: a transfer happens on a rising edge where valid && ready; the producer holds
    // its payload until then, and the consumer-facing result is held while out_valid && !out_ready.
    localparam int W  = BIT_SIZE;
    localparam int CW = $clog2(BIT_SIZE) + 1;

    typedef enum logic [1:0] {IDLE, MUL, ADD, DONE} state_t;

    state_t        state_q;
    logic          mode_q, bad_q, err_q;
    logic [W-1:0]  a0_q, a1_q, y_q, q_q, m_q, r_q, b0_q, b1_q;
    logic [CW-1:0] cnt_q;

    logic          accept, range_bad;
    logic [W:0]    gs_raw, add_sum, sub_raw;
    logic [W-1:0]  m_d, r_d, b0_d, b1_d, addend;
    logic [W+1:0]  q_ext, r_dbl, r_sub1;

    assign accept    = in_valid && in_ready;
    assign in_ready  = rstn && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign B0        = b0_q;
    assign B1        = b1_q;
    assign err       = err_q;

`ifdef BU_RANGE_CHECK_EN
    assign range_bad = (A0 >= q) || (A1 >= q) || (Y >= q) || (q < W'(2));
`else
    assign range_bad = 1'b0;
`endif

    // GS multiplicand (A0 - A1) mod q, formed at capture; a borrow is fixed by adding q once.
    always_comb begin
        gs_raw = {1'b0, A0} - {1'b0, A1};
        m_d    = mode ? W'(gs_raw[W] ? gs_raw + {1'b0, q} : gs_raw) : A1;
    end

    // One interleaved multiply step: r <- 2r + bit*m, then at most two subtractions of q.
    always_comb begin
        q_ext  = {2'b00, q_q};
        r_dbl  = {1'b0, r_q, 1'b0} + (y_q[W-1] ? {2'b00, m_q} : '0);
        r_sub1 = (r_dbl >= q_ext) ? r_dbl - q_ext : r_dbl;
        r_d    = W'((r_sub1 >= q_ext) ? r_sub1 - q_ext : r_sub1);
    end

    always_comb begin
        addend  = mode_q ? a1_q : r_q;
        add_sum = {1'b0, a0_q} + {1'b0, addend};
        sub_raw = {1'b0, a0_q} - {1'b0, r_q};
        b0_d    = W'((add_sum >= {1'b0, q_q}) ? add_sum - {1'b0, q_q} : add_sum);
        b1_d    = mode_q ? r_q : W'(sub_raw[W] ? sub_raw + {1'b0, q_q} : sub_raw);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            mode_q  <= 1'b0;
            bad_q   <= 1'b0;
            err_q   <= 1'b0;
            a0_q    <= '0;
            a1_q    <= '0;
            y_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            r_q     <= '0;
            b0_q    <= '0;
            b1_q    <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    mode_q  <= mode;
                    bad_q   <= range_bad;
                    a0_q    <= A0;
                    a1_q    <= A1;
                    y_q     <= Y;
                    q_q     <= q;
                    m_q     <= m_d;
                    r_q     <= '0;
                    cnt_q   <= '0;
                    state_q <= range_bad ? ADD : MUL;
                end
                MUL: begin
                    r_q   <= r_d;
                    y_q   <= {y_q[W-2:0], 1'b0};
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(BIT_SIZE - 1)) state_q <= ADD;
                end
                ADD: begin
                    b0_q    <= bad_q ? '0 : b0_d;
                    b1_q    <= bad_q ? '0 : b1_d;
                    err_q   <= bad_q;
                    state_q <= DONE;
                end
                DONE: if (out_ready) begin
                    err_q   <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ntt_butterfly_seq.sv
// Scoreboard bench for ntt_butterfly_seq: a big-integer reference model feeds an expected queue,
// a negedge monitor pops and compares each presented result, checks latency, hold and recovery.
module tb_ntt_butterfly_seq;
    localparam int W = 60;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic         mode = 1'b0;
    logic [W-1:0] A0 = '0, A1 = '0, Y = '0, q = '0;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] B0, B1;
    logic         err;

    ntt_butterfly_seq #(.BIT_SIZE(W)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .A0(A0), .A1(A1), .Y(Y), .q(q), .out_valid(out_valid), .out_ready(out_ready),
        .B0(B0), .B1(B1), .err(err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2*W:0] exp_q[$];
    int           acc_q[$];
    int           lat_q[$];

    // 0: always ready, 1: random backpressure, 2: directed level from dir_ready
    int   bp_mode = 0;
    logic dir_ready = 1'b1;
    always @(posedge clk) begin
        #1;
        if (bp_mode == 0) out_ready = 1'b1;
        else if (bp_mode == 1) out_ready = 1'($urandom_range(0, 1));
        else out_ready = dir_ready;
    end
    initial out_ready = 1'b1;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] expv);
        n_vec++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, expv, cyc);
        end
    endtask

    function automatic logic [2*W:0] model(input logic md, input logic [W-1:0] a0, a1, y, qq);
        logic [127:0] x0, x1, yy, m, t, s, d;
        x0 = 128'(a0); x1 = 128'(a1); yy = 128'(y); m = 128'(qq);
`ifdef BU_RANGE_CHECK_EN
        if (a0 >= qq || a1 >= qq || y >= qq || qq < 2) return {1'b1, {(2*W){1'b0}}};
`endif
        if (!md) begin
            t = (x1 * yy) % m;
            s = (x0 + t) % m;
            d = (x0 + m - t) % m;
        end else begin
            s = (x0 + x1) % m;
            d = (((x0 + m - x1) % m) * yy) % m;
        end
        return {1'b0, s[W-1:0], d[W-1:0]};
    endfunction

    function automatic logic [W-1:0] rand60();
        logic [63:0] v;
        v = {$urandom(), $urandom()};
        return v[W-1:0];
    endfunction

    task automatic send(input logic md, input logic [W-1:0] a0, a1, y, qq);
        int t;
        logic [2*W:0] e;
        @(negedge clk);
        mode = md; A0 = a0; A1 = a1; Y = y; q = qq; in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        e = model(md, a0, a1, y, qq);
        exp_q.push_back(e);
        acc_q.push_back(cyc);
        lat_q.push_back(e[2*W] ? 1 : W + 1);
        in_valid = 1'b0;
        // Capture must be immune to later input activity.
        mode = ~md; A0 = rand60(); A1 = rand60(); Y = rand60(); q = rand60();
    endtask

    // Monitor
    logic         hold_valid = 1'b0;
    logic         prev_hs = 1'b0;
    logic [2*W:0] held;
    always @(negedge clk) begin
        logic [2*W:0] e;
        int a, l;
        if (!rstn) begin
            hold_valid = 1'b0;
            prev_hs = 1'b0;
        end else begin
            if (prev_hs) begin
                check("in_ready_after_handshake", 128'(in_ready), 1);
                check("out_valid_after_handshake", 128'(out_valid), 0);
            end
            prev_hs = 1'b0;
            if (out_valid) begin
                check("in_ready_while_done", 128'(in_ready), 0);
                if (hold_valid) begin
                    check("held_result", 128'({err, B0, B1}), 128'(held));
                end else if (exp_q.size() == 0) begin
                    check("spurious_out_valid", 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    l = lat_q.pop_front();
                    check("latency", 128'(cyc - a), 128'(l));
                    check("B0", 128'(B0), 128'(e[2*W-1:W]));
                    check("B1", 128'(B1), 128'(e[W-1:0]));
                    check("err", 128'(err), 128'(e[2*W]));
                end
                if (out_ready) begin
                    hold_valid = 1'b0;
                    prev_hs = 1'b1;
                end else begin
                    hold_valid = 1'b1;
                    held = {err, B0, B1};
                end
            end
        end
    end

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || out_valid) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("drain_timeout", 128'(exp_q.size()), 0);
    endtask

    initial begin
        logic [W-1:0] qq, qmax;
        int t;
        // Reset state
        #1;
        check("rst_in_ready", 128'(in_ready), 0);
        check("rst_out_valid", 128'(out_valid), 0);
        check("rst_B", 128'({err, B0, B1}), 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("in_ready_after_reset", 128'(in_ready), 1);

        // Directed vectors
        send(1'b0, 60'd5000, 60'd7000, 60'd3000, 60'd9000);
        send(1'b1, 60'd5000, 60'd7000, 60'd3000, 60'd9000);
        send(1'b0, 60'd100, 60'd8999, 60'd1, 60'd9000);
        qmax = '1;
        send(1'b0, 60'd0, qmax - 1, qmax - 1, qmax);
        send(1'b1, qmax - 1, 60'd0, qmax - 1, qmax);
        drain();

        // Directed backpressure: hold out_ready low for 5 cycles of out_valid
        bp_mode = 2;
        dir_ready = 1'b0;
        send(1'b0, 60'd1234, 60'd4321, 60'd777, 60'd8191);
        t = 0;
        while (!out_valid && t < 500) begin
            @(negedge clk);
            t++;
        end
        check("bp_out_valid_seen", 128'(out_valid), 1);
        repeat (5) @(negedge clk);
        dir_ready = 1'b1;
        drain();
        bp_mode = 0;

        // Reset in the middle of MUL
        send(1'b1, 60'd42, 60'd17, 60'd99, 60'd101);
        repeat (20) @(posedge clk);
        #2 rstn = 1'b0;
        #1;
        check("midrst_out_valid", 128'(out_valid), 0);
        check("midrst_in_ready", 128'(in_ready), 0);
        check("midrst_B", 128'({err, B0, B1}), 0);
        exp_q.delete();
        acc_q.delete();
        lat_q.delete();
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        check("midrst_in_ready_release", 128'(in_ready), 1);
        check("midrst_no_result", 128'(out_valid), 0);
        send(1'b0, 60'd5000, 60'd7000, 60'd3000, 60'd9000);
        drain();

`ifdef BU_RANGE_CHECK_EN
        send(1'b0, 60'd9000, 60'd7000, 60'd3000, 60'd9000);
        send(1'b1, 60'd5, 60'd7, 60'd3, 60'd1);
        send(1'b0, 60'd5, 60'd9, 60'd3, 60'd9);
        drain();
`endif

        // Randomized traffic with random backpressure
        bp_mode = 1;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) qq = W'($urandom_range(2, 20000));
            else qq = rand60();
            if (qq < 2) qq = 2;
            send(1'($urandom_range(0, 1)), rand60() % qq, rand60() % qq, rand60() % qq, qq);
        end
        drain();
        bp_mode = 0;
        repeat (4) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
